// File: rtl/asrv32_commit_trace_if.sv
// asrv32_commit_trace_if
//   Groups the commit-trace signals: the retire bus and halt inputs coming
//   from the core writeback stage, the trace stream going to the consumer,
//   and the status outputs.
//   slave  : view used by asrv32_commit_trace (retire/halt inputs, trace/status outputs)
//   master : view used by the producer/consumer side (the opposite directions)
interface asrv32_commit_trace_if;
  logic         i_retire_valid;
  logic [31:0]  i_retire_pc;
  logic [31:0]  i_retire_inst;
  logic         i_rd_wr_en;
  logic [4:0]   i_rd_addr;
  logic [31:0]  i_rd_data;
  logic         i_mem_wr_en;
  logic [31:0]  i_mem_addr;
  logic [31:0]  i_mem_data;
  logic [3:0]   i_mem_mask;
  logic         i_trap;
  logic         i_mret;
  logic         i_ecall;
  logic         i_ebreak;
  logic [31:0]  i_a0;
  logic [31:0]  i_a7;
  logic         o_trace_valid;
  logic         i_trace_ready;
  logic [172:0] o_trace_entry;
  logic         o_overflow;
  logic [15:0]  o_drop_count;
  logic [31:0]  o_retire_count;
  logic [31:0]  o_cycle_count;
  logic         o_halted;
  logic         o_pass;
  logic         o_fail;
  logic         o_unknown;
  logic [30:0]  o_exit_code;

  modport slave (
    input  i_retire_valid, i_retire_pc, i_retire_inst, i_rd_wr_en, i_rd_addr,
           i_rd_data, i_mem_wr_en, i_mem_addr, i_mem_data, i_mem_mask,
           i_trap, i_mret, i_ecall, i_ebreak, i_a0, i_a7, i_trace_ready,
    output o_trace_valid, o_trace_entry, o_overflow, o_drop_count,
           o_retire_count, o_cycle_count, o_halted, o_pass, o_fail,
           o_unknown, o_exit_code
  );

  modport master (
    output i_retire_valid, i_retire_pc, i_retire_inst, i_rd_wr_en, i_rd_addr,
           i_rd_data, i_mem_wr_en, i_mem_addr, i_mem_data, i_mem_mask,
           i_trap, i_mret, i_ecall, i_ebreak, i_a0, i_a7, i_trace_ready,
    input  o_trace_valid, o_trace_entry, o_overflow, o_drop_count,
           o_retire_count, o_cycle_count, o_halted, o_pass, o_fail,
           o_unknown, o_exit_code
  );
endinterface

// File: rtl/asrv32_commit_trace.sv
// asrv32_commit_trace
//   Captures every instruction retired by the asrv32 writeback stage into a
//   show-ahead trace FIFO that drains over a valid/ready stream. On ecall or
//   ebreak the block stops capturing, drains the FIFO and then reports halt
//   together with the riscv-tests exit status decoded from a7/a0.
// Ports
//   i_clk, i_rst : core clock, asynchronous active-high reset
//   tr (slave)   : retire bus, halt inputs (ecall/ebreak/a0/a7), trace
//                  stream (o_trace_valid/i_trace_ready/o_trace_entry) and
//                  status (overflow, drop/retire/cycle counters, halted,
//                  pass/fail/unknown, exit code)
// Trace entry layout (173 bits, MSB first):
//   {mret, trap, mem_wr, rd_wr, mask[3:0], mem_data, mem_addr, rd_data,
//    rd_addr[4:0], inst, pc}
module asrv32_commit_trace #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] EXIT_A7    = 32'h0000_005d
) (
  input logic                  i_clk,
  input logic                  i_rst,
  asrv32_commit_trace_if.slave tr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 173;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          write_s;
  logic          drop_s;
  logic          halt_evt_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;
  logic          overflow_r;
  logic [15:0]   drop_cnt_r;
  logic [31:0]   retire_cnt_r;
  logic [31:0]   cycle_cnt_r;
  logic          pass_r;
  logic          fail_r;
  logic          unknown_r;
  logic [30:0]   exit_code_r;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s      = !empty_s && tr.i_trace_ready;
  assign push_s     = tr.i_retire_valid && (state_r == ST_RUN);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign write_s    = push_s && (!full_s || pop_s);
  assign drop_s     = push_s && full_s && !pop_s;
  assign halt_evt_s = (state_r == ST_RUN) && (tr.i_ecall || tr.i_ebreak);

  assign entry_s = {tr.i_mret, tr.i_trap, tr.i_mem_wr_en, tr.i_rd_wr_en,
                    tr.i_mem_mask, tr.i_mem_data, tr.i_mem_addr, tr.i_rd_data,
                    tr.i_rd_addr, tr.i_retire_inst, tr.i_retire_pc};

  // Halt sequencer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Halt sequencer next state: stop capture on halt, finish once drained.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (tr.i_ecall || tr.i_ebreak) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Trace storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
    end
  end

  // FIFO pointers, overflow flag and saturating drop counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) begin
          drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
      end
    end
  end

  // Retire and cycle counters run only while capturing; dropped retires still count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retire_cnt_r <= 32'h0000_0000;
      cycle_cnt_r  <= 32'h0000_0000;
    end else if (state_r == ST_RUN) begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      if (tr.i_retire_valid) begin
        retire_cnt_r <= retire_cnt_r + 32'h0000_0001;
      end
    end
  end

  // Exit status is sampled only on the RUN->DRAIN edge; later halts are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      unknown_r   <= 1'b0;
      exit_code_r <= 31'h0000_0000;
    end else if (halt_evt_s) begin
      pass_r      <= (tr.i_a7 == EXIT_A7) && (tr.i_a0 == 32'h0000_0000);
      fail_r      <= (tr.i_a7 == EXIT_A7) && (tr.i_a0 != 32'h0000_0000);
      unknown_r   <= (tr.i_a7 != EXIT_A7);
      exit_code_r <= tr.i_a0[31:1];
    end
  end

  // Show-ahead head; forced to zero while empty so stale data never leaks out.
  always_comb begin
    head_s = {EW{1'b0}};
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      head_s = {EW{1'b0}};
    end
  end

  assign tr.o_trace_valid  = !empty_s;
  assign tr.o_trace_entry  = head_s;
  assign tr.o_overflow     = overflow_r;
  assign tr.o_drop_count   = drop_cnt_r;
  assign tr.o_retire_count = retire_cnt_r;
  assign tr.o_cycle_count  = cycle_cnt_r;
  assign tr.o_halted       = (state_r == ST_DONE);
  // Decode results are held back until the trace has fully drained.
  assign tr.o_pass         = pass_r    && (state_r == ST_DONE);
  assign tr.o_fail         = fail_r    && (state_r == ST_DONE);
  assign tr.o_unknown      = unknown_r && (state_r == ST_DONE);
  assign tr.o_exit_code    = exit_code_r;
endmodule

// File: tb/tb_asrv32_commit_trace.sv
// tb_asrv32_commit_trace
//   Drives retires into asrv32_commit_trace and compares the trace stream and
//   status against a queue-based reference model of the trace FIFO and halt
//   behaviour.
module tb_asrv32_commit_trace;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  asrv32_commit_trace_if tr ();

  asrv32_commit_trace #(.FIFO_DEPTH(DEPTH), .EXIT_A7(32'h0000_005d)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .tr    (tr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = capturing, 1 = draining, 2 = done.
  logic [172:0] mq[$];
  int           m_st;
  logic [15:0]  m_drop;
  logic         m_ovf;
  logic [31:0]  m_ret;
  logic [31:0]  m_cyc;
  logic         m_pass, m_fail, m_unk;
  logic [30:0]  m_code;

  function automatic logic [172:0] cur_entry();
    return {tr.i_mret, tr.i_trap, tr.i_mem_wr_en, tr.i_rd_wr_en, tr.i_mem_mask,
            tr.i_mem_data, tr.i_mem_addr, tr.i_rd_data, tr.i_rd_addr,
            tr.i_retire_inst, tr.i_retire_pc};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st = 0; m_drop = 16'h0; m_ovf = 1'b0; m_ret = 32'h0; m_cyc = 32'h0;
    m_pass = 1'b0; m_fail = 1'b0; m_unk = 1'b0; m_code = 31'h0;
  endtask

  task automatic clear_inputs();
    tr.i_retire_valid = 1'b0; tr.i_retire_pc = 32'h0; tr.i_retire_inst = 32'h0;
    tr.i_rd_wr_en = 1'b0; tr.i_rd_addr = 5'h0; tr.i_rd_data = 32'h0;
    tr.i_mem_wr_en = 1'b0; tr.i_mem_addr = 32'h0; tr.i_mem_data = 32'h0;
    tr.i_mem_mask = 4'h0; tr.i_trap = 1'b0; tr.i_mret = 1'b0;
    tr.i_ecall = 1'b0; tr.i_ebreak = 1'b0; tr.i_a0 = 32'h0; tr.i_a7 = 32'h0;
    tr.i_trace_ready = 1'b0;
  endtask

  task automatic set_retire(input logic [31:0] pc);
    tr.i_retire_valid = 1'b1; tr.i_retire_pc = pc; tr.i_retire_inst = $urandom;
    tr.i_rd_wr_en = 1'($urandom); tr.i_rd_addr = 5'($urandom); tr.i_rd_data = $urandom;
    tr.i_mem_wr_en = 1'($urandom); tr.i_mem_addr = $urandom; tr.i_mem_data = $urandom;
    tr.i_mem_mask = 4'($urandom); tr.i_trap = 1'($urandom); tr.i_mret = 1'($urandom);
  endtask

  // Advance the model by the clock edge about to happen, then take that edge.
  task automatic step();
    bit pop_b, push_b;
    pop_b  = (mq.size() > 0) && tr.i_trace_ready;
    push_b = tr.i_retire_valid && (m_st == 0);
    if (m_st == 0) begin
      m_cyc = m_cyc + 32'h1;
      if (tr.i_retire_valid) m_ret = m_ret + 32'h1;
    end
    if (push_b && mq.size() == DEPTH && !pop_b) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
      push_b = 1'b0;
    end
    if (m_st == 1 && mq.size() == 0) begin
      m_st = 2;
    end else if (m_st == 0 && (tr.i_ecall || tr.i_ebreak)) begin
      m_st   = 1;
      m_pass = (tr.i_a7 == 32'h5d) && (tr.i_a0 == 32'h0);
      m_fail = (tr.i_a7 == 32'h5d) && (tr.i_a0 != 32'h0);
      m_unk  = (tr.i_a7 != 32'h5d);
      m_code = tr.i_a0[31:1];
    end
    if (pop_b) void'(mq.pop_front());
    if (push_b) mq.push_back(cur_entry());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (tr.o_trace_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0d want 0", tr.o_trace_valid); end
    n_cmp++; if (tr.o_trace_entry !== 173'h0) begin n_bad++; $display("FAIL reset_entry got %h want 0", tr.o_trace_entry); end
    n_cmp++; if (tr.o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0d want 0", tr.o_overflow); end
    n_cmp++; if (tr.o_drop_count !== 16'h0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", tr.o_drop_count); end
    n_cmp++; if (tr.o_retire_count !== 32'h0) begin n_bad++; $display("FAIL reset_retire got %0d want 0", tr.o_retire_count); end
    n_cmp++; if (tr.o_cycle_count !== 32'h0) begin n_bad++; $display("FAIL reset_cycle got %0d want 0", tr.o_cycle_count); end
    n_cmp++; if ({tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown} !== 4'h0) begin n_bad++; $display("FAIL reset_status got %b want 0000", {tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown}); end
    n_cmp++; if (tr.o_exit_code !== 31'h0) begin n_bad++; $display("FAIL reset_exit got %0d want 0", tr.o_exit_code); end
  endtask

  task automatic test_basic();
    int k;
    apply_reset();
    tr.i_trace_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) set_retire(32'(i * 4)); else tr.i_retire_valid = 1'b0;
      if (tr.o_trace_valid) begin
        n_cmp++; if (tr.o_trace_entry[31:0] !== 32'(k * 4)) begin n_bad++; $display("FAIL basic_pc got %h want %h", tr.o_trace_entry[31:0], 32'(k * 4)); end
        n_cmp++; if (tr.o_trace_entry !== mq[0]) begin n_bad++; $display("FAIL basic_entry got %h want %h", tr.o_trace_entry, mq[0]); end
        k++;
      end
      step();
    end
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL basic_count got %0d want 5", k); end
    n_cmp++; if (tr.o_retire_count !== 32'd5) begin n_bad++; $display("FAIL basic_retire got %0d want 5", tr.o_retire_count); end
    n_cmp++; if (tr.o_overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow got %0d want 0", tr.o_overflow); end
  endtask

  task automatic test_overflow();
    int k;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_retire(32'h100 + 32'(i * 4));
      step();
    end
    tr.i_retire_valid = 1'b0;
    n_cmp++; if (tr.o_drop_count !== 16'd4) begin n_bad++; $display("FAIL ovf_drop got %0d want 4", tr.o_drop_count); end
    n_cmp++; if (tr.o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0d want 1", tr.o_overflow); end
    n_cmp++; if (tr.o_retire_count !== 32'd20) begin n_bad++; $display("FAIL ovf_retire got %0d want 20", tr.o_retire_count); end
    tr.i_trace_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && tr.o_trace_valid; i++) begin
      n_cmp++; if (tr.o_trace_entry[31:0] !== 32'h100 + 32'(k * 4)) begin n_bad++; $display("FAIL ovf_pc got %h want %h", tr.o_trace_entry[31:0], 32'h100 + 32'(k * 4)); end
      k++;
      step();
    end
    n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", k); end
  endtask

  task automatic test_full_push_pop();
    int k;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_retire(32'h400 + 32'(i * 4));
      step();
    end
    tr.i_trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_retire(32'h800 + 32'(i * 4));
      step();
    end
    tr.i_retire_valid = 1'b0;
    n_cmp++; if (tr.o_drop_count !== 16'd0) begin n_bad++; $display("FAIL fpp_drop got %0d want 0", tr.o_drop_count); end
    n_cmp++; if (tr.o_overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow got %0d want 0", tr.o_overflow); end
    k = 0;
    for (int i = 0; i < 40 && tr.o_trace_valid; i++) begin
      n_cmp++; if (tr.o_trace_entry !== mq[0]) begin n_bad++; $display("FAIL fpp_entry got %h want %h", tr.o_trace_entry, mq[0]); end
      k++;
      step();
    end
    n_cmp++; if (k !== DEPTH) begin n_bad++; $display("FAIL fpp_count got %0d want %0d", k, DEPTH); end
  endtask

  task automatic test_halt_pass();
    int k;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_retire(32'h2000 + 32'(i * 4));
      step();
    end
    tr.i_retire_valid = 1'b0;
    tr.i_ecall = 1'b1; tr.i_a7 = 32'h5d; tr.i_a0 = 32'h0;
    step();
    // A later ebreak with a non-exit a7 must not disturb the latched result.
    tr.i_ecall = 1'b0; tr.i_ebreak = 1'b1; tr.i_a7 = 32'h0; tr.i_a0 = 32'h5;
    tr.i_trace_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && !(m_st == 2); i++) begin
      n_cmp++; if (tr.o_halted !== 1'b0) begin n_bad++; $display("FAIL hp_early_halt got %0d want 0 after %0d pops", tr.o_halted, k); end
      n_cmp++; if (tr.o_pass !== 1'b0) begin n_bad++; $display("FAIL hp_gated_pass got %0d want 0", tr.o_pass); end
      if (tr.o_trace_valid) k++;
      step();
    end
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL hp_pops got %0d want 3", k); end
    n_cmp++; if (tr.o_halted !== 1'b1) begin n_bad++; $display("FAIL hp_halted got %0d want 1", tr.o_halted); end
    n_cmp++; if ({tr.o_pass, tr.o_fail, tr.o_unknown} !== 3'b100) begin n_bad++; $display("FAIL hp_status got %b want 100", {tr.o_pass, tr.o_fail, tr.o_unknown}); end
    n_cmp++; if (tr.o_exit_code !== 31'd0) begin n_bad++; $display("FAIL hp_exit got %0d want 0", tr.o_exit_code); end
    n_cmp++; if (tr.o_retire_count !== 32'd3) begin n_bad++; $display("FAIL hp_retire got %0d want 3", tr.o_retire_count); end
    n_cmp++; if (tr.o_cycle_count !== m_cyc) begin n_bad++; $display("FAIL hp_cycle got %0d want %0d", tr.o_cycle_count, m_cyc); end
  endtask

  task automatic test_halt_fail_unknown();
    apply_reset();
    tr.i_trace_ready = 1'b1;
    set_retire(32'h40);
    tr.i_ecall = 1'b1; tr.i_a7 = 32'h5d; tr.i_a0 = 32'd7;
    step();
    clear_inputs();
    tr.i_trace_ready = 1'b1;
    for (int i = 0; i < 10 && !(m_st == 2); i++) step();
    n_cmp++; if ({tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown} !== 4'b1010) begin n_bad++; $display("FAIL hf_status got %b want 1010", {tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown}); end
    n_cmp++; if (tr.o_exit_code !== 31'd3) begin n_bad++; $display("FAIL hf_exit got %0d want 3", tr.o_exit_code); end
    n_cmp++; if (tr.o_retire_count !== 32'd1) begin n_bad++; $display("FAIL hf_retire got %0d want 1", tr.o_retire_count); end

    apply_reset();
    tr.i_ebreak = 1'b1; tr.i_a7 = 32'h0; tr.i_a0 = 32'd9;
    step();
    clear_inputs();
    for (int i = 0; i < 10 && !(m_st == 2); i++) step();
    n_cmp++; if ({tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown} !== 4'b1001) begin n_bad++; $display("FAIL hu_status got %b want 1001", {tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown}); end
    n_cmp++; if (tr.o_exit_code !== 31'd4) begin n_bad++; $display("FAIL hu_exit got %0d want 4", tr.o_exit_code); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_retire(32'h3000 + 32'(i * 4));
      step();
    end
    tr.i_retire_valid = 1'b0;
    tr.i_ecall = 1'b1; tr.i_a7 = 32'h5d; tr.i_a0 = 32'h0;
    step();
    clear_inputs();
    n_cmp++; if (tr.o_trace_valid !== 1'b1) begin n_bad++; $display("FAIL rd_pending got %0d want 1", tr.o_trace_valid); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if ({tr.o_trace_valid, tr.o_overflow, tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown} !== 6'h0) begin n_bad++; $display("FAIL rd_flags got %b want 000000", {tr.o_trace_valid, tr.o_overflow, tr.o_halted, tr.o_pass, tr.o_fail, tr.o_unknown}); end
    n_cmp++; if ({tr.o_retire_count, tr.o_cycle_count, tr.o_drop_count} !== 80'h0) begin n_bad++; $display("FAIL rd_counts got %h want 0", {tr.o_retire_count, tr.o_cycle_count, tr.o_drop_count}); end
    n_cmp++; if (tr.o_trace_entry !== 173'h0) begin n_bad++; $display("FAIL rd_entry got %h want 0", tr.o_trace_entry); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (tr.o_trace_valid !== 1'b0) begin n_bad++; $display("FAIL rd_empty got %0d want 0", tr.o_trace_valid); end
    set_retire(32'h77);
    step();
    tr.i_retire_valid = 1'b0;
    n_cmp++; if (tr.o_trace_entry[31:0] !== 32'h77 || tr.o_trace_valid !== 1'b1) begin n_bad++; $display("FAIL rd_run_capture got %h/%0d want 77/1", tr.o_trace_entry[31:0], tr.o_trace_valid); end
    n_cmp++; if (tr.o_retire_count !== 32'd1) begin n_bad++; $display("FAIL rd_run_retire got %0d want 1", tr.o_retire_count); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) set_retire($urandom); else tr.i_retire_valid = 1'b0;
      tr.i_trace_ready = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      n_cmp++; if (tr.o_trace_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0d want %0d", i, tr.o_trace_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_cmp++; if (tr.o_trace_entry !== mq[0]) begin n_bad++; $display("FAIL rnd_entry cyc %0d got %h want %h", i, tr.o_trace_entry, mq[0]); end
      end
      n_cmp++; if ({tr.o_overflow, tr.o_drop_count} !== {m_ovf, m_drop}) begin n_bad++; $display("FAIL rnd_drop cyc %0d got %h want %h", i, {tr.o_overflow, tr.o_drop_count}, {m_ovf, m_drop}); end
      n_cmp++; if ({tr.o_retire_count, tr.o_cycle_count} !== {m_ret, m_cyc}) begin n_bad++; $display("FAIL rnd_counts cyc %0d got %h want %h", i, {tr.o_retire_count, tr.o_cycle_count}, {m_ret, m_cyc}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_halt_pass();
    test_halt_fail_unknown();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
